// File: rtl/accumulator_sequencer_pkg.sv
// Shared types and helpers for the systolic-array result collector.
package accumulator_sequencer_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  localparam int DATA_W_DEFAULT = 32;

  // A zero or oversized row count means "use the full buffer depth".
  function automatic int norm_rows(input int n, input int depth);
    return (n == 0 || n > depth) ? depth : n;
  endfunction

endpackage

// File: rtl/acc_col_wr_ctr.sv
// Per-column saturating write pointer; flags writes that arrive once the column is full.
module acc_col_wr_ctr
  import accumulator_sequencer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1,
  parameter int ROW_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] rows,
  output logic [ROW_W-1:0] wr_addr,
  output logic             wr_en,
  output logic             full,
  output logic             full_next,
  output logic             overrun
);

  logic [CNT_W-1:0] count_reg;

  assign full      = (count_reg == rows);
  assign wr_en     = inc && !full;
  assign overrun   = inc && full;
  // Looks one write ahead so the sequencer can enter DRAIN right after the last beat.
  assign full_next = full || (wr_en && ((count_reg + CNT_W'(1)) == rows));
  assign wr_addr   = count_reg[ROW_W-1:0];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (wr_en) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/accumulator_sequencer.sv
// Collects skewed per-column partial sums into a row buffer, then drains full rows
// over a valid/ready handshake.
module accumulator_sequencer
  import accumulator_sequencer_pkg::*;
#(
  parameter int NUM_COLS = 2,
  parameter int DEPTH    = 2,
  parameter int DATA_W   = DATA_W_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(DEPTH):0]       num_rows,
  input  logic [NUM_COLS-1:0]          col_valid,
  input  logic [NUM_COLS*DATA_W-1:0]   col_data,
  output logic                         busy,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [NUM_COLS*DATA_W-1:0]   rd_data,
  output logic [$clog2(DEPTH)-1:0]     rd_row,
  output logic                         rd_last,
  output logic                         done,
  output logic                         err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ROW_W = $clog2(DEPTH);

  state_t           state_reg;
  logic [CNT_W-1:0] rows_reg;
  logic [ROW_W-1:0] rd_ptr_reg;
  logic             rd_valid_reg;
  logic             done_reg;
  logic             err_reg;

  logic [DATA_W-1:0] row_buf [DEPTH][NUM_COLS];

  logic [ROW_W-1:0]    wr_addr [NUM_COLS];
  logic [NUM_COLS-1:0] wr_en;
  logic [NUM_COLS-1:0] full;
  logic [NUM_COLS-1:0] full_next;
  logic [NUM_COLS-1:0] overrun;

  logic start_acc;
  logic collecting;

  assign start_acc  = start && (state_reg == IDLE);
  assign collecting = (state_reg == COLLECT);

  generate
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
      acc_col_wr_ctr #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .ROW_W (ROW_W)
      ) u_ctr (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_acc),
        .inc       (collecting && col_valid[gi]),
        .rows      (rows_reg),
        .wr_addr   (wr_addr[gi]),
        .wr_en     (wr_en[gi]),
        .full      (full[gi]),
        .full_next (full_next[gi]),
        .overrun   (overrun[gi])
      );
    end
  endgenerate

  // Buffer contents survive start and reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_COLS; c++) begin
      if (wr_en[c]) begin
        row_buf[wr_addr[c]][c] <= col_data[c*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_valid_reg) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        rd_data[c*DATA_W +: DATA_W] = row_buf[rd_ptr_reg][c];
      end
    end
  end

  assign busy     = (state_reg != IDLE);
  assign rd_valid = rd_valid_reg;
  assign rd_row   = rd_valid_reg ? rd_ptr_reg : '0;
  assign rd_last  = rd_valid_reg && ({1'b0, rd_ptr_reg} == (rows_reg - CNT_W'(1)));
  assign done     = done_reg;
  assign err      = err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      rows_reg     <= CNT_W'(DEPTH);
      rd_ptr_reg   <= '0;
      rd_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg  <= COLLECT;
            rows_reg   <= CNT_W'(norm_rows(int'(num_rows), DEPTH));
            rd_ptr_reg <= '0;
            err_reg    <= 1'b0;
          end
        end
        COLLECT: begin
          if (|overrun) err_reg <= 1'b1;
          if (&full_next) begin
            state_reg    <= DRAIN;
            rd_valid_reg <= 1'b1;
          end
        end
        DRAIN: begin
          if (|col_valid) err_reg <= 1'b1;
          if (rd_ready) begin
            if (rd_last) begin
              state_reg    <= IDLE;
              rd_valid_reg <= 1'b0;
              done_reg     <= 1'b1;
            end else begin
              rd_ptr_reg <= rd_ptr_reg + ROW_W'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Self-checking bench: table-driven tiles plus hand-written overrun, ignored-control and reset cases.
module tb_accumulator_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  num_rows;
  logic [1:0]  col_valid;
  logic [63:0] col_data;
  logic        busy;
  logic        rd_valid;
  logic        rd_ready;
  logic [63:0] rd_data;
  logic [0:0]  rd_row;
  logic        rd_last;
  logic        done;
  logic        err;

  accumulator_sequencer #(.NUM_COLS(2), .DEPTH(2), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_rows  (num_rows),
    .col_valid (col_valid),
    .col_data  (col_data),
    .busy      (busy),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_row    (rd_row),
    .rd_last   (rd_last),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    int          row;
    bit          last;
  } exp_t;

  typedef struct {
    int          rows;
    logic [31:0] a0, a1, b0, b1;
    int          skew;
    int          stall;
  } vec_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int eff_rows(input int r);
    return (r == 0 || r > 2) ? 2 : r;
  endfunction

  task automatic push_rows(input int n, input logic [31:0] a0, a1, b0, b1);
    exp_t e;
    for (int r = 0; r < n; r++) begin
      e.data = (r == 0) ? {b0, a0} : {b1, a1};
      e.row  = r;
      e.last = (r == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_tile(input int rows);
    start    = 1'b1;
    num_rows = 2'(rows);
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_after_start", err, 0);
  endtask

  task automatic drive(input bit v0, input logic [31:0] d0, input bit v1, input logic [31:0] d1);
    col_valid = {v1, v0};
    col_data  = {d1, d0};
    tick();
    col_valid = 2'b00;
    col_data  = '0;
  endtask

  task automatic collect(input int n, input logic [31:0] a0, a1, b0, b1, input int skew);
    for (int i = 0; i < n + skew; i++) begin
      int j;
      j = i - skew;
      if (i == n + skew - 1) check("rd_valid_before_last_write", rd_valid, 0);
      drive(i < n, (i == 0) ? a0 : a1, (j >= 0 && j < n), (j == 0) ? b0 : b1);
    end
    check("rd_valid_after_collect", rd_valid, 1);
    check("rd_row_first", rd_row, 0);
  endtask

  task automatic drain(input int stall);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      rd_ready = (cyc >= stall);
      check("rd_valid", rd_valid, 1);
      check("done_in_drain", done, 0);
      check("rd_data", rd_data, exp_q[0].data);
      check("rd_row", rd_row, exp_q[0].row);
      check("rd_last", rd_last, exp_q[0].last);
      if (rd_ready) e = exp_q.pop_front();
      tick();
      cyc++;
    end
    rd_ready = 1'b0;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d rows left expected 0", exp_q.size());
      exp_q.delete();
    end
    check("done_pulse", done, 1);
    check("busy_after_done", busy, 0);
    check("rd_valid_after_done", rd_valid, 0);
    check("rd_data_idle", rd_data, 0);
    tick();
    check("done_single", done, 0);
  endtask

  vec_t vecs[5];
  exp_t dummy;

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    num_rows  = 2'd0;
    col_valid = 2'b00;
    col_data  = '0;
    rd_ready  = 1'b0;

    vecs[0] = '{rows: 2, a0: 5,  a1: 7,  b0: 6,  b1: 8,  skew: 1, stall: 0};
    vecs[1] = '{rows: 2, a0: 0,  a1: 3,  b0: 6,  b1: 8,  skew: 1, stall: 0};
    vecs[2] = '{rows: 2, a0: 9,  a1: 10, b0: 11, b1: 12, skew: 0, stall: 3};
    vecs[3] = '{rows: 0, a0: 1,  a1: 2,  b0: 3,  b1: 4,  skew: 0, stall: 1};
    vecs[4] = '{rows: 1, a0: 42, a1: 0,  b0: 43, b1: 0,  skew: 2, stall: 0};

    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_row", rd_row, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rd_data", rd_data, 0);

    // Table-driven tiles.
    for (int v = 0; v < 5; v++) begin
      int n;
      n = eff_rows(vecs[v].rows);
      $display("tile %0d rows=%0d skew=%0d stall=%0d", v, n, vecs[v].skew, vecs[v].stall);
      start_tile(vecs[v].rows);
      push_rows(n, vecs[v].a0, vecs[v].a1, vecs[v].b0, vecs[v].b1);
      collect(n, vecs[v].a0, vecs[v].a1, vecs[v].b0, vecs[v].b1, vecs[v].skew);
      check("err_clean_tile", err, 0);
      drain(vecs[v].stall);
    end

    // Overrun: second col0 beat with one row configured is dropped.
    $display("overrun tile");
    start_tile(1);
    drive(1, 32'd5, 0, 32'd0);
    drive(1, 32'd9, 0, 32'd0);
    check("err_overrun", err, 1);
    check("busy_overrun", busy, 1);
    push_rows(1, 32'd5, 32'd0, 32'd6, 32'd0);
    drive(0, 32'd0, 1, 32'd6);
    check("rd_valid_overrun", rd_valid, 1);
    drain(0);
    check("err_sticky_idle", err, 1);
    start_tile(2);
    check("err_cleared_by_start", err, 0);
    push_rows(2, 32'd21, 32'd22, 32'd23, 32'd24);
    collect(2, 32'd21, 32'd22, 32'd23, 32'd24, 0);
    drain(0);

    // Ignored controls: col_valid in IDLE, start during COLLECT.
    $display("ignored controls");
    drive(1, 32'd77, 1, 32'd78);
    drive(1, 32'd79, 1, 32'd80);
    check("idle_err", err, 0);
    check("idle_busy", busy, 0);
    check("idle_rd_valid", rd_valid, 0);
    start_tile(2);
    push_rows(2, 32'd31, 32'd32, 32'd33, 32'd34);
    drive(1, 32'd31, 0, 32'd0);
    start    = 1'b1;
    num_rows = 2'd1;
    drive(0, 32'd0, 1, 32'd33);
    start = 1'b0;
    check("start_in_collect_rd_valid", rd_valid, 0);
    check("start_in_collect_busy", busy, 1);
    drive(1, 32'd32, 0, 32'd0);
    check("rows_kept_rd_valid", rd_valid, 0);
    drive(0, 32'd0, 1, 32'd34);
    check("rows_kept_done_collect", rd_valid, 1);
    check("err_ignored", err, 0);
    drain(0);

    // Mid-operation reset after one handshake, with err raised in DRAIN.
    $display("mid-operation reset");
    start_tile(2);
    push_rows(2, 32'd51, 32'd52, 32'd53, 32'd54);
    collect(2, 32'd51, 32'd52, 32'd53, 32'd54, 1);
    drive(0, 32'd0, 1, 32'd99);
    check("err_in_drain", err, 1);
    check("row0_after_drain_beat", rd_data, exp_q[0].data);
    rd_ready = 1'b1;
    dummy = exp_q.pop_front();
    tick();
    rd_ready = 1'b0;
    check("row1_before_reset", rd_data, exp_q[0].data);
    check("row1_index_before_reset", rd_row, 1);
    exp_q.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_rd_data", rd_data, 0);
    start_tile(2);
    push_rows(2, 32'd61, 32'd62, 32'd63, 32'd64);
    collect(2, 32'd61, 32'd62, 32'd63, 32'd64, 0);
    drain(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accumulator_sequencer.md
# accumulator_sequencer

Controls the collection and readout of systolic-array results. It captures the per-column partial sums streamed out of the array's bottom edge into a row buffer. Each column has its own write pointer, so column skew is absorbed. Every accepted beat is written, including zero-valued data. Once all columns have delivered the configured row count, it drains complete product rows to the downstream consumer (unified buffer or bench) over a valid/ready handshake.

## Interface
Parameters:
- NUM_COLS, 2, number of systolic-array columns feeding the block
- DEPTH, 2, maximum rows per tile held in the buffer
- DATA_W, 32, width of one accumulated value

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a new tile; honoured only in IDLE
- num_rows  in  $clog2(DEPTH)+1  rows per tile, latched on accepted start; 0 or >DEPTH means DEPTH
- col_valid  in  NUM_COLS  per-column result strobe
- col_data  in  NUM_COLS*DATA_W  per-column result; column c at bits [c*DATA_W +: DATA_W]
- busy  out  1  high when state ≠ IDLE
- rd_valid  out  1  a complete row is presented
- rd_ready  in  1  consumer accepts the row
- rd_data  out  NUM_COLS*DATA_W  current row, same packing as col_data
- rd_row  out  $clog2(DEPTH)  index of the presented row
- rd_last  out  1  presented row is the final row of the tile
- done  out  1  one-cycle pulse after the final row is accepted
- err  out  1  sticky overrun flag; cleared by reset or accepted start

## Operation
- States:
  - IDLE → COLLECT on start.
  - COLLECT → DRAIN when every column's write count equals the latched row count.
  - DRAIN → IDLE on the handshake of the last row.
- IDLE:
  - col_valid and rd_ready are ignored.
  - start latches num_rows, clears all write pointers, read pointer and err, and does not clear buffer contents.
- COLLECT:
  - Per column c, col_valid[c]=1 writes col_data[c] to buf[wr_ptr[c]][c] and increments wr_ptr[c].
  - Zero-valued data is written and counted like any other value.
  - Columns advance independently; any subset may be valid in a cycle.
  - col_valid[c] when wr_ptr[c] already equals the row count: the write is dropped, the pointer holds, and err is set.
- DRAIN:
  - rd_valid=1; rd_data = buf[rd_ptr]; rd_row = rd_ptr; rd_last = (rd_ptr == rows−1).
  - rd_valid && rd_ready advances rd_ptr.
  - col_valid in DRAIN is dropped and sets err.
- start outside IDLE is ignored and has no side effects.
- Reset mid-operation:
  - Next state IDLE; all pointers 0; err 0.
  - Buffer contents are don't-care.
- Reset values: busy 0, rd_valid 0, rd_row 0, rd_last 0, done 0, err 0, rd_data 0.
  - rd_data must be driven 0 whenever rd_valid=0.

## Timing
- start accepted at edge T: busy=1 from T+1. col_valid is sampled from the cycle after T onward; col_valid in the start cycle itself is ignored.
- Final column write at edge T: state DRAIN, rd_valid=1 and row 0 presented from T+1. Transition latency is 1 cycle.
- rd_data, rd_row and rd_last are stable while rd_valid && !rd_ready.
- Each handshake at edge T presents the next row at T+1. Throughput is one row per cycle with rd_ready held high.
- Last-row handshake at edge T: done=1 and busy=0 during T+1; rd_valid=0 at T+1.
- start is legal in the same cycle done is high, since the block is already in IDLE.
- Pointer widths:
  - write pointers count 0..DEPTH inclusive;
  - the read pointer wraps only through reset or start, never modulo DEPTH.

## Structure
- Package accumulator_sequencer_pkg:
  - state typedef (IDLE, COLLECT, DRAIN);
  - DATA_W default;
  - helper function normalising num_rows (0/out-of-range → DEPTH).
- Sub-module acc_col_wr_ctr, one instance per column:
  - saturating write counter with clear, inc and full outputs, plus an overrun strobe feeding err.
- Buffer: flat register array of DEPTH×NUM_COLS, written only by the top level.

## Test plan
(All cases use NUM_COLS=2, DEPTH=2.)
- **Basic tile.** start with num_rows=2; col0 valid 5 then 7, col1 valid one cycle later with 6 then 8.
  - rd row0={6,5}, row1={8,7}; rd_last only on row1; done pulses once; err=0.
- **Zero data.** Same as basic, col0 data 0 then 3.
  - Row0 col0 = 0 is captured; tile completes with two rows; the pointer does not stall.
- **Backpressure.** rd_ready low for 3 cycles in DRAIN.
  - rd_valid held, rd_data/rd_row stable, no row skipped.
  - Row1 appears the cycle after the handshake.
- **Overrun.** num_rows=1; col0 pulses twice.
  - Second write dropped and err=1; row0 col0 holds the first value; err clears on next start.
- **Ignored controls.**
  - start during COLLECT: no change to pointers or num_rows.
  - col_valid in IDLE: no write, err stays 0.
- **Mid-operation reset.** Assert reset in DRAIN after one handshake.
  - Next cycle busy=0, rd_valid=0, done=0, err=0.
  - A new tile completes normally.
